// File: rtl/edge_detector_multi.sv
// Multi-channel resynchronising edge detector with per-channel rise/fall/both selection and sticky flags.
// Optional saturating per-channel event counters are built when EDGE_DET_COUNTER_EN is defined.
module edge_detector_multi #(
    parameter int   NCH         = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0,
    parameter int   CNT_WIDTH   = 8
) (
    input  logic                     dstclk,
    input  logic                     dstresetn,
    input  logic [NCH-1:0]           srcdata,
    input  logic [2*NCH-1:0]         edgemode,
    input  logic [NCH-1:0]           stickyclear,
`ifdef EDGE_DET_COUNTER_EN
    input  logic                     cntclear,
    output logic [NCH*CNT_WIDTH-1:0] evtcount,
`endif
    output logic [NCH-1:0]           dstdata,
    output logic [NCH-1:0]           stickyflag
);

    if (NCH < 1 || NCH > 32) begin : g_bad_nch
        $error("edge_detector_multi: NCH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("edge_detector_multi: SYNC_STAGES must be 2..4");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("edge_detector_multi: CNT_WIDTH must be at least 1");
    end

    logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NCH-1:0]                  hist_q, hist_d;
    logic [2*NCH-1:0]                mode_q, mode_d;
    logic [NCH-1:0]                  sticky_q, sticky_d;
    logic [NCH-1:0]                  sync_last, rise, fall, pulse;

    // Edge detection depends only on flops, so the pulse output cannot glitch.
    always_comb begin
        sync_last = '0;
        rise      = '0;
        fall      = '0;
        pulse     = '0;
        for (int i = 0; i < NCH; i++) begin
            sync_last[i] = sync_q[i][SYNC_STAGES-1];
            rise[i]      = sync_last[i] & ~hist_q[i];
            fall[i]      = ~sync_last[i] & hist_q[i];
            pulse[i]     = (mode_q[2*i] & rise[i]) | (mode_q[2*i+1] & fall[i]);
        end
    end

    always_comb begin
        sync_d = sync_q;
        for (int i = 0; i < NCH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], srcdata[i]};
        end
        hist_d   = sync_last;
        mode_d   = edgemode;
        // A new event on the same cycle as a clear leaves the flag set.
        sticky_d = (sticky_q & ~stickyclear) | pulse;
    end

    always_ff @(posedge dstclk or negedge dstresetn) begin
        if (!dstresetn) begin
            sync_q   <= {(NCH*SYNC_STAGES){RESET_LEVEL}};
            hist_q   <= {NCH{RESET_LEVEL}};
            mode_q   <= '0;
            sticky_q <= '0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            mode_q   <= mode_d;
            sticky_q <= sticky_d;
        end
    end

    assign dstdata    = pulse;
    assign stickyflag = sticky_q;

`ifdef EDGE_DET_COUNTER_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NCH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Clear takes priority over accumulation but still counts a coincident event.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (cntclear) begin
                cnt_d[i] = pulse[i] ? CNT_WIDTH'(1) : '0;
            end else if (pulse[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge dstclk or negedge dstresetn) begin
        if (!dstresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign evtcount = cnt_q;
`endif

endmodule

// File: doc/edge_detector_multi.md
# edge_detector_multi

Parametrised multi-channel edge detector: each channel resynchronises an asynchronous 1-bit source into the `dstclk` domain and emits a one-cycle pulse on a rising, falling or either edge, selectable per channel at run time. It generalises the single-channel falling-edge resynchroniser with configurable synchroniser depth, reset level, sticky event flags and optional saturating event counters. It sits at the MAC clock-domain boundary, feeding interrupt and status logic from PHY/host-side asynchronous signals.

## Interface
- `NCH`, 4: number of independent channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flops per channel before the history flop (2..4).
- `RESET_LEVEL`, 1'b0: reset value of all synchroniser and history flops.
- `CNT_WIDTH`, 8: event counter width per channel (used only with `EDGE_DET_COUNTER_EN`).

Ports:
- `dstclk` in 1: destination clock.
- `dstresetn` in 1: reset, asynchronous, active-low.
- `srcdata` in NCH: asynchronous source levels, bit i = channel i.
- `edgemode` in 2*NCH: per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- `stickyclear` in NCH: synchronous clear of the sticky flag, per channel.
- `cntclear` in 1: synchronous clear of all event counters (present only with macro).
- `dstdata` out NCH: one-cycle edge pulse per channel.
- `stickyflag` out NCH: latched "edge seen" flag per channel.
- `evtcount` out NCH*CNT_WIDTH: per-channel event counts, channel i at [CNT_WIDTH*(i+1)-1:CNT_WIDTH*i] (present only with macro).

## Operation
- Per channel: chain sync[0..SYNC_STAGES-1] ← `srcdata[i]`, history flop hist ← sync[SYNC_STAGES-1], every `dstclk` edge.
- `edgemode` registered each cycle into mode_q; detection uses mode_q only.
- rise = sync_last & ~hist; fall = ~sync_last & hist.
- `dstdata[i]` = (mode_q[0] & rise) | (mode_q[1] & fall); combinational from registers only, glitch-free.
- Mode 00: `dstdata` and sticky/counter updates suppressed; synchroniser and history keep running, so re-enabling produces no spurious edge for a static input.
- Sticky: set when `dstdata[i]`=1; cleared when `stickyclear[i]`=1; simultaneous set and clear → flag stays 1 (set wins).
- Reset (asynchronous): sync, hist = RESET_LEVEL; mode_q = 00; `stickyflag` = 0; counters = 0; hence `dstdata` = 0. Deassertion is glitch-free; a source at the opposite level of RESET_LEVEL produces one edge pulse SYNC_STAGES cycles after release if enabled.
- Reset mid-operation: all state drops immediately; in-flight pulses lost.
- Pulses narrower than one `dstclk` period may be missed; edges closer than SYNC_STAGES+1 cycles are not guaranteed to be distinguished.

## Timing
- Source change setup-met before edge E (captured into sync[0] at E): `dstdata` high from E+SYNC_STAGES-1 to E+SYNC_STAGES, exactly one cycle.
- `stickyflag` and `evtcount` reflect the pulse from edge E+SYNC_STAGES.
- `edgemode` change at edge M takes effect for detection from M+1.
- `stickyclear`, `cntclear`: effective at the next edge.

## Configuration
- Macro `EDGE_DET_COUNTER_EN`.
- Defined: `cntclear` and `evtcount` exist; each channel counter increments on its `dstdata` pulse, saturates at 2^CNT_WIDTH-1; `cntclear` resets all to 0; simultaneous `cntclear` and pulse → count = 1.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- NCH=4, SYNC_STAGES=2, RESET_LEVEL=0, mode 10 on ch0: `srcdata[0]` 1→0 captured at edge E → `dstdata[0]`=1 for the cycle between E+1 and E+2 only; other channels 0.
- Mode 11 on ch1, `srcdata[1]` toggled every 8 cycles 4 times → 4 single-cycle pulses, `stickyflag[1]`=1, `evtcount` ch1 = 4 (macro on).
- RESET_LEVEL=0, `srcdata[2]`=1 held through reset, mode 01 → exactly one pulse at SYNC_STAGES cycles after `dstresetn` rise; RESET_LEVEL=1 → none.
- `stickyclear[0]` asserted in same cycle as a ch0 pulse → `stickyflag[0]` stays 1; next cycle clear alone → 0.
- CNT_WIDTH=2, 5 edges on ch3 → count saturates at 3; `cntclear` coincident with a pulse → count = 1.
- Ch0 mode 00 during 3 toggles, then mode 01 with input static high → no pulses, no sticky, count 0; `dstresetn` pulsed low mid-activity → all outputs 0 immediately.
